// File: rtl/alu_op_issue.sv
// ID->EX operand issue stage: decodes a MIPS instruction and its register values into an ALU op and
// operands, then buffers the result in a two-entry valid/ready skid buffer toward the EX-stage ALU.

package alu_op_pkg;
  localparam logic [3:0] ALU_add     = 4'd0;
  localparam logic [3:0] ALU_sub     = 4'd1;
  localparam logic [3:0] ALU_and     = 4'd2;
  localparam logic [3:0] ALU_or      = 4'd3;
  localparam logic [3:0] ALU_slt     = 4'd4;
  localparam logic [3:0] ALU_sll     = 4'd5;
  localparam logic [3:0] ALU_sra     = 4'd6;
  localparam logic [3:0] ALU_slli    = 4'd7;
  localparam logic [3:0] ALU_imm_nop = 4'd8;
  localparam logic [3:0] ALU_undef   = 4'd15;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [31:0] lvalue;
    logic [31:0] rvalue;
    logic [4:0]  shamt;
    logic        illegal;
  } payload_t;

  localparam payload_t PAYLOAD_RESET = '{aluop: ALU_add, lvalue: 32'd0, rvalue: 32'd0,
                                         shamt: 5'd0, illegal: 1'b0};
endpackage

module alu_op_issue
  import alu_op_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [3:0]  ex_aluOP,
  output logic [31:0] ex_lvalue,
  output logic [31:0] ex_rvalue,
  output logic [4:0]  ex_shamt,
  output logic        ex_illegal
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  function automatic payload_t decode(input logic [31:0] instr, input logic [31:0] rs,
                                      input logic [31:0] rt);
    payload_t    p;
    logic [31:0] se_imm;
    logic [31:0] ze_imm;
    se_imm = {{16{instr[15]}}, instr[15:0]};
    ze_imm = {16'd0, instr[15:0]};
    // Undecodable words still drive defined zero operands so EX never sees X.
    p = '{aluop: ALU_undef, lvalue: 32'd0, rvalue: 32'd0, shamt: 5'd0, illegal: 1'b1};
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h20, 6'h21: p = '{ALU_add, rs, rt, 5'd0, 1'b0};
          6'h22, 6'h23: p = '{ALU_sub, rs, rt, 5'd0, 1'b0};
          6'h24:        p = '{ALU_and, rs, rt, 5'd0, 1'b0};
          6'h25:        p = '{ALU_or,  rs, rt, 5'd0, 1'b0};
          6'h2A:        p = '{ALU_slt, rs, rt, 5'd0, 1'b0};
          6'h00:        p = '{ALU_sll, rt, 32'd0, instr[10:6], 1'b0};
          6'h03:        p = '{ALU_sra, rt, 32'd0, instr[10:6], 1'b0};
          default:      ;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: p = '{ALU_add, rs, se_imm, 5'd0, 1'b0};
      6'h0A:                      p = '{ALU_slt, rs, se_imm, 5'd0, 1'b0};
      6'h0C:                      p = '{ALU_and, rs, ze_imm, 5'd0, 1'b0};
      6'h0D:                      p = '{ALU_or,  rs, ze_imm, 5'd0, 1'b0};
      6'h04, 6'h05:               p = '{ALU_sub, rs, rt, 5'd0, 1'b0};
      6'h0F:                      p = '{ALU_slli, 32'd0, ze_imm, 5'd16, 1'b0};
      6'h02:                      p = '{ALU_imm_nop, 32'd0, 32'd0, 5'd0, 1'b0};
      default:                    ;
    endcase
    return p;
  endfunction

  logic [1:0] state_q, state_d;
  logic       id_ready_q, ex_valid_q;
  payload_t   main_q, main_d;
  payload_t   skid_q, skid_d;
  payload_t   dec;
  logic       accept, send;

  assign dec    = decode(id_instr, id_rs_val, id_rt_val);
  assign accept = id_valid & id_ready_q;
  assign send   = ex_valid_q & ex_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin
          state_d = S_ONE;
          main_d  = dec;
        end
        S_ONE: begin
          if (accept && send) begin
            main_d = dec;
          end else if (accept) begin
            state_d = S_FULL;
            skid_d  = dec;
          end else if (send) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: if (send) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the skid entry is reset too so it
  // never holds X, as it is a handful of flops rather than a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      id_ready_q <= 1'b1;
      ex_valid_q <= 1'b0;
      main_q     <= PAYLOAD_RESET;
      skid_q     <= PAYLOAD_RESET;
    end else begin
      state_q    <= state_d;
      id_ready_q <= (state_d != S_FULL);
      ex_valid_q <= (state_d != S_EMPTY);
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign id_ready   = id_ready_q;
  assign ex_valid   = ex_valid_q;
  assign ex_aluOP   = main_q.aluop;
  assign ex_lvalue  = main_q.lvalue;
  assign ex_rvalue  = main_q.rvalue;
  assign ex_shamt   = main_q.shamt;
  assign ex_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: hand-derived expected payloads are queued on accept and
// compared in order as EX consumes them; handshake, flush and reset behaviour are checked inline.
`timescale 1ns/1ps

module tb_alu_op_issue;
  import alu_op_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_aluOP;
  logic [31:0] ex_lvalue;
  logic [31:0] ex_rvalue;
  logic [4:0]  ex_shamt;
  logic        ex_illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  payload_t exp_q[$];

  alu_op_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_rs_val  (id_rs_val),
    .id_rt_val  (id_rt_val),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_aluOP   (ex_aluOP),
    .ex_lvalue  (ex_lvalue),
    .ex_rvalue  (ex_rvalue),
    .ex_shamt   (ex_shamt),
    .ex_illegal (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every transfer EX takes must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      payload_t got;
      got = '{ex_aluOP, ex_lvalue, ex_rvalue, ex_shamt, ex_illegal};
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_output got op=%0d L=%h R=%h sh=%0d ill=%0b, none expected",
                 got.aluop, got.lvalue, got.rvalue, got.shamt, got.illegal);
      end else begin
        payload_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          tests_failed++;
          $display("FAIL payload got op=%0d L=%h R=%h sh=%0d ill=%0b, expected op=%0d L=%h R=%h sh=%0d ill=%0b",
                   got.aluop, got.lvalue, got.rvalue, got.shamt, got.illegal,
                   e.aluop, e.lvalue, e.rvalue, e.shamt, e.illegal);
        end
      end
    end
  end

  function automatic payload_t mk(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r,
                                  input logic [4:0] sh, input logic ill);
    payload_t p;
    p = '{op, l, r, sh, ill};
    return p;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the instruction.
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                       input payload_t exp);
    int budget;
    budget    = 0;
    id_valid  = 1'b1;
    id_instr  = instr;
    id_rs_val = rs;
    id_rt_val = rt;
    @(negedge clk);
    while (!id_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!id_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL issue_timeout instr=%h id_ready stayed %0b, expected 1", instr, id_ready);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    id_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout got %0d entries left, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string name);
    tests_run++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1 || ex_aluOP !== ALU_add || ex_lvalue !== 32'd0 ||
        ex_rvalue !== 32'd0 || ex_shamt !== 5'd0 || ex_illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s got v=%0b rdy=%0b op=%0d L=%h R=%h sh=%0d ill=%0b, expected 0 1 %0d 0 0 0 0",
               name, ex_valid, id_ready, ex_aluOP, ex_lvalue, ex_rvalue, ex_shamt, ex_illegal,
               ALU_add);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    id_valid = 1'b0;
    id_instr = 32'd0;
    id_rs_val = 32'd0;
    id_rt_val = 32'd0;
    ex_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("post_reset_idle");
  endtask

  task automatic test_rtype();
    ex_ready = 1'b1;
    issue(32'h00221820, 32'd5, 32'd7, mk(ALU_add, 32'd5, 32'd7, 5'd0, 1'b0));
    tests_run++;
    if (ex_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_latency got ex_valid=%0b, expected 1", ex_valid);
    end
    issue(32'h00221822, 32'd9, 32'd4, mk(ALU_sub, 32'd9, 32'd4, 5'd0, 1'b0));
    issue(32'h00221824, 32'hF0F0, 32'h0FF0, mk(ALU_and, 32'hF0F0, 32'h0FF0, 5'd0, 1'b0));
    issue(32'h00221825, 32'h1, 32'h2, mk(ALU_or, 32'h1, 32'h2, 5'd0, 1'b0));
    issue(32'h0022182A, 32'hFFFFFFFF, 32'h3, mk(ALU_slt, 32'hFFFFFFFF, 32'h3, 5'd0, 1'b0));
    wait_drain();
  endtask

  task automatic test_immediate();
    ex_ready = 1'b1;
    issue(32'h2022FFFF, 32'h10, 32'h99, mk(ALU_add, 32'h10, 32'hFFFFFFFF, 5'd0, 1'b0));
    issue(32'h3422FFFF, 32'h10, 32'h99, mk(ALU_or, 32'h10, 32'h0000FFFF, 5'd0, 1'b0));
    issue(32'h8C22FFF0, 32'h400, 32'h0, mk(ALU_add, 32'h400, 32'hFFFFFFF0, 5'd0, 1'b0));
    issue(32'h30228001, 32'hABCD, 32'h0, mk(ALU_and, 32'hABCD, 32'h00008001, 5'd0, 1'b0));
    issue(32'h2822FFFE, 32'h7, 32'h0, mk(ALU_slt, 32'h7, 32'hFFFFFFFE, 5'd0, 1'b0));
    issue(32'h10220003, 32'h11, 32'h22, mk(ALU_sub, 32'h11, 32'h22, 5'd0, 1'b0));
    issue(32'h08000010, 32'h11, 32'h22, mk(ALU_imm_nop, 32'd0, 32'd0, 5'd0, 1'b0));
    wait_drain();
  endtask

  task automatic test_shift();
    ex_ready = 1'b1;
    issue(32'h00021900, 32'hDEAD, 32'd1, mk(ALU_sll, 32'd1, 32'd0, 5'd4, 1'b0));
    issue(32'h3C011234, 32'h5555, 32'h6666, mk(ALU_slli, 32'd0, 32'h1234, 5'd16, 1'b0));
    issue(32'h00021FC3, 32'h1, 32'h80000000, mk(ALU_sra, 32'h80000000, 32'd0, 5'd31, 1'b0));
    issue(32'h00000000, 32'h1, 32'h2, mk(ALU_sll, 32'h2, 32'd0, 5'd0, 1'b0));
    wait_drain();
  endtask

  task automatic test_back_to_back();
    ex_ready = 1'b0;
    issue(32'h00221820, 32'd1, 32'd1, mk(ALU_add, 32'd1, 32'd1, 5'd0, 1'b0));
    issue(32'h00221820, 32'd2, 32'd2, mk(ALU_add, 32'd2, 32'd2, 5'd0, 1'b0));
    id_valid  = 1'b1;
    id_instr  = 32'h00221820;
    id_rs_val = 32'd3;
    id_rt_val = 32'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (id_ready !== 1'b0 || ex_valid !== 1'b1 || ex_lvalue !== 32'd1) begin
        tests_failed++;
        $display("FAIL full_hold got rdy=%0b v=%0b L=%h, expected 0 1 00000001",
                 id_ready, ex_valid, ex_lvalue);
      end
    end
    @(posedge clk);
    #1;
    ex_ready = 1'b1;
    issue(32'h00221820, 32'd3, 32'd3, mk(ALU_add, 32'd3, 32'd3, 5'd0, 1'b0));
    wait_drain();
  endtask

  task automatic test_illegal_flush();
    ex_ready = 1'b1;
    issue(32'hFC000000, 32'h12345678, 32'h9ABCDEF0, mk(ALU_undef, 32'd0, 32'd0, 5'd0, 1'b1));
    issue(32'h0022183F, 32'h1, 32'h2, mk(ALU_undef, 32'd0, 32'd0, 5'd0, 1'b1));
    wait_drain();
    ex_ready = 1'b0;
    issue(32'h00221820, 32'd4, 32'd4, mk(ALU_add, 32'd4, 32'd4, 5'd0, 1'b0));
    issue(32'h00221820, 32'd5, 32'd5, mk(ALU_add, 32'd5, 32'd5, 5'd0, 1'b0));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    tests_run++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_full got v=%0b rdy=%0b, expected 0 1", ex_valid, id_ready);
    end
    issue(32'h00221820, 32'd6, 32'd6, mk(ALU_add, 32'd6, 32'd6, 5'd0, 1'b0));
    id_valid = 1'b1;
    id_instr = 32'h00221820;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    id_valid = 1'b0;
    exp_q.delete();
    tests_run++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_accept got v=%0b rdy=%0b, expected 0 1", ex_valid, id_ready);
    end
    ex_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    ex_ready = 1'b0;
    issue(32'h00221820, 32'd7, 32'd7, mk(ALU_add, 32'd7, 32'd7, 5'd0, 1'b0));
    issue(32'h3C011234, 32'd8, 32'd8, mk(ALU_slli, 32'd0, 32'h1234, 5'd16, 1'b0));
    tests_run++;
    if (id_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL pre_reset_full got rdy=%0b, expected 0", id_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("after_async_reset");
    ex_ready = 1'b1;
    issue(32'h00221820, 32'd2, 32'd3, mk(ALU_add, 32'd2, 32'd3, 5'd0, 1'b0));
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_immediate();
    test_shift();
    test_back_to_back();
    test_illegal_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
